fp16_mul_normalize: RTL and testbench

Downstream stage of the 10x10 fraction multiplier in the float MAC datapath. It takes two FP16 operands plus the 20-bit product of their fraction fields and reconstructs the full significand product. It then normalizes and rounds (round-to-nearest-even) and emits a packed FP16 product. It is a two-stage pipeline with valid/ready handshakes on both sides and feeds the MAC accumulator.

---
 rtl/fp16_mul_normalize.sv | 176 +++++++++++++++++
 tb/tb_fp16_mul_normalize.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_normalize.sv
// FP16 multiply back end: rebuilds the significand product from the fraction
// product, normalizes, rounds to nearest-even and packs the result.
// Two pipeline stages (operand/product register, output register) with
// valid/ready handshakes on both sides.
module fp16_mul_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_op,
  input  logic [15:0] b_op,
  input  logic [19:0] frac_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_ovf,
  output logic        out_unf
);

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  // stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic [21:0]       s1_p_q, s1_p_d;
  logic [6:0]        s1_e_q, s1_e_d;
  logic [1:0]        s1_cls_q, s1_cls_d;
  logic              s1_sign_q, s1_sign_d;

  // output registers
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_result_q, out_result_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_unf_q, out_unf_d;

  logic              s2_adv;
  logic              accept;

  // stage 1 datapath signals
  logic [4:0]        ea, eb;
  logic              a_zero, b_zero, a_inf, b_inf;
  logic [1:0]        cls_in;
  logic [10:0]       fsum;

  // stage 2 datapath signals
  logic [9:0]        m_n, m_r;
  logic              g_n, s_n, rnd;
  logic signed [6:0] e_n, e_r;
  logic [15:0]       res;
  logic              res_ovf, res_unf;

  assign s2_adv    = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign accept    = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign out_unf    = out_unf_q;

  // operand classification and unnormalized significand product
  always_comb begin
    ea     = a_op[14:10];
    eb     = b_op[14:10];
    a_zero = (ea == 5'd0);
    b_zero = (eb == 5'd0);
    a_inf  = (ea == 5'd31);
    b_inf  = (eb == 5'd31);
    fsum   = {1'b0, a_op[9:0]} + {1'b0, b_op[9:0]};
    if ((a_inf && b_zero) || (b_inf && a_zero)) cls_in = CLS_NAN;
    else if (a_inf || b_inf)                    cls_in = CLS_INF;
    else if (a_zero || b_zero)                  cls_in = CLS_ZERO;
    else                                        cls_in = CLS_NORM;
  end

  // stage 1 capture: loads whenever the stage is empty or draining
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_e_d     = s1_e_q;
    s1_cls_d   = s1_cls_q;
    s1_sign_d  = s1_sign_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        // (1+fa)(1+fb) scaled by 2^20: hidden-bit term, cross terms, fraction product
        s1_p_d    = 22'h100000 + {1'b0, fsum, 10'b0} + {2'b00, frac_prod};
        s1_e_d    = {2'b00, ea} + {2'b00, eb} - 7'd15;
        s1_cls_d  = cls_in;
        s1_sign_d = a_op[15] ^ b_op[15];
      end
    end
  end

  // normalize, round-to-nearest-even, and select special results
  always_comb begin
    if (s1_p_q[21]) begin
      m_n = s1_p_q[20:11];
      g_n = s1_p_q[10];
      s_n = |s1_p_q[9:0];
      e_n = s1_e_q + 7'sd1;
    end else begin
      m_n = s1_p_q[19:10];
      g_n = s1_p_q[9];
      s_n = |s1_p_q[8:0];
      e_n = s1_e_q;
    end
    rnd = g_n && (s_n || m_n[0]);
    m_r = m_n + {9'd0, rnd};
    // mantissa carry-out means the significand became exactly 2.0
    e_r = e_n + ((rnd && (m_n == 10'h3ff)) ? 7'sd1 : 7'sd0);

    res_ovf = 1'b0;
    res_unf = 1'b0;
    case (s1_cls_q)
      CLS_NAN:  res = 16'h7E00;
      CLS_INF:  res = {s1_sign_q, 15'h7C00};
      CLS_ZERO: res = {s1_sign_q, 15'h0000};
      default: begin
        if (e_r >= 7'sd31) begin
          res     = {s1_sign_q, 15'h7C00};
          res_ovf = 1'b1;
        end else if (e_r <= 7'sd0) begin
          res     = {s1_sign_q, 15'h0000};
          res_unf = 1'b1;
        end else begin
          res = {s1_sign_q, e_r[4:0], m_r};
        end
      end
    endcase
  end

  // output register: holds while the consumer stalls
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    out_unf_d    = out_unf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = res;
        out_ovf_d    = res_ovf;
        out_unf_d    = res_unf;
      end
    end
  end

  // pipeline state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_p_q       <= '0;
      s1_e_q       <= '0;
      s1_cls_q     <= CLS_NORM;
      s1_sign_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 16'h0000;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_p_q       <= s1_p_d;
      s1_e_q       <= s1_e_d;
      s1_cls_q     <= s1_cls_d;
      s1_sign_q    <= s1_sign_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_unf_q    <= out_unf_d;
    end
  end

endmodule

// File: tb/tb_fp16_mul_normalize.sv
// Scoreboard bench for fp16_mul_normalize: a driver pushes the expected
// {ovf, unf, result} at each accepted transfer, a monitor pops on every
// output transfer.
module tb_fp16_mul_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_op = '0;
  logic [15:0] b_op = '0;
  logic [19:0] frac_prod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  fp16_mul_normalize dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_op(a_op), .b_op(b_op), .frac_prod(frac_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sent = 0;
  int rcvd = 0;
  int cyc = 0;
  bit rnd_mode = 1'b0;
  logic [17:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [17:0] e;   // {ovf, unf, result}
  } vec_t;

  localparam int NV = 21;
  vec_t dv [0:NV-1] = '{
    '{16'h3E00, 16'h3E00, 18'h04080},  // normalize shift
    '{16'h3C01, 16'h3C01, 18'h03C02},  // round down
    '{16'h3C01, 16'h3E00, 18'h03E02},  // tie, odd -> up
    '{16'h3C03, 16'h3E00, 18'h03E04},  // tie, even -> stays
    '{16'h3FFE, 16'h3C01, 18'h04000},  // round carries into exponent
    '{16'h3BFF, 16'h3C01, 18'h03C00},
    '{16'hBC00, 16'h3C00, 18'h0BC00},
    '{16'h7C00, 16'h0000, 18'h07E00},  // inf x zero
    '{16'h8000, 16'hFC00, 18'h07E00},
    '{16'h7BFF, 16'h7BFF, 18'h27C00},  // overflow
    '{16'hFBFF, 16'h7BFF, 18'h2FC00},
    '{16'h0400, 16'h0400, 18'h10000},  // underflow
    '{16'h7800, 16'h4000, 18'h27C00},  // E = 31
    '{16'h7800, 16'h3C00, 18'h07800},  // E = 30
    '{16'h0400, 16'h3800, 18'h10000},  // E = 0
    '{16'h0400, 16'h3C00, 18'h00400},  // E = 1
    '{16'h7BFF, 16'h3C01, 18'h27C00},  // normalize pushes to 31
    '{16'hFC00, 16'h3C00, 18'h0FC00},
    '{16'h7C01, 16'hC000, 18'h0FC00},  // nonzero-fraction inf
    '{16'h8000, 16'h3C00, 18'h08000},
    '{16'h0001, 16'h3C00, 18'h00000}   // subnormal flushed
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // independent FP16 multiply reference (flush-to-zero, RNE)
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    int e;
    int unsigned prod, m, rem, half, sh;
    logic s = a[15] ^ b[15];
    bit za = (ea == 0), zb = (eb == 0), ia = (ea == 31), ib = (eb == 31);
    logic [31:0] ev;
    if ((ia && zb) || (ib && za)) return 18'h07E00;
    if (ia || ib) return {2'b00, s, 15'h7C00};
    if (za || zb) return {2'b00, s, 15'h0000};
    prod = (32'd1024 + 32'(a[9:0])) * (32'd1024 + 32'(b[9:0]));
    e = ea + eb - 15;
    sh = (prod >= 32'h200000) ? 11 : 10;
    if (sh == 11) e++;
    m = prod >> sh;
    rem = prod & ((32'd1 << sh) - 1);
    half = 32'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m++;
    if (m == 2048) begin m = 1024; e++; end
    if (e >= 31) return {2'b10, s, 15'h7C00};
    if (e <= 0)  return {2'b01, s, 15'h0000};
    ev = 32'(e);
    return {2'b00, s, ev[4:0], m[9:0]};
  endfunction

  always @(posedge clk) cyc++;

  // issue one operand set, block until accepted, then record expectation
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [17:0] e);
    int n = 0;
    bit ok = 1'b0;
    a_op = a;
    b_op = b;
    frac_prod = 20'(a[9:0]) * 20'(b[9:0]);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    else begin
      exp_q.push_back(e);
      sent++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((in_valid || exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare on every output transfer
  always @(negedge clk) begin : mon
    logic [17:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", {14'd0, out_ovf, out_unf, out_result}, 32'hFFFFFFFF);
      else begin
        e = exp_q.pop_front();
        chk("result", {14'd0, out_ovf, out_unf, out_result}, {14'd0, e});
        rcvd++;
      end
    end
  end

  // random consumer backpressure during the stream phase
  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = ($urandom % 3) != 0;
    end
  end

  initial begin
    int c0;
    logic [15:0] ra, rb;
    // reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    chk("rst_flags", {30'd0, out_ovf, out_unf}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // first transfer latency
    send(16'h3C00, 16'h3C00, 18'h03C00);
    @(negedge clk);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    drain();

    // directed vectors back to back: one accept per cycle
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(dv[i].a, dv[i].b, dv[i].e);
    chk("full_rate_cycles", 32'(cyc - c0), 32'(NV));
    drain();

    // backpressure: two held, third waits
    out_ready = 1'b0;
    send(16'h3C01, 16'h3C01, 18'h03C02);
    send(16'h3C01, 16'h3E00, 18'h03E02);
    fork
      send(16'hBC00, 16'h3C00, 18'h0BC00);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", {15'd0, out_valid, out_result}, {15'd0, 1'b1, 16'h3C02});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(16'h3E00, 16'h3E00, 18'h04080);
    send(16'h3C00, 16'h3C00, 18'h03C00);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", {14'd0, out_ovf, out_unf, out_result}, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    sent = rcvd;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    send(16'hBC00, 16'h3E00, 18'h0BE00);
    @(negedge clk);
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", {15'd0, out_valid, out_result}, {15'd0, 1'b1, 16'hBE00});
    drain();

    // random stream against the reference model
    rnd_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      send(ra, rb, model(ra, rb));
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    chk("stream_count", 32'(rcvd), 32'(sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
